sram_like_responder: RTL and testbench
======================================

Name: sram_like_responder

Overview:
- Responder (slave) end of the team's sram-like bus (req/wr/size/addr/wstrb/wdata/addr_ok/data_ok/rdata).
- Backs the bus with an internal word-addressed memory array.
- Accepts up to DEPTH outstanding requests and returns responses strictly in order after a fixed LATENCY.
- Used as the instruction/data memory model behind fetch and memory stages, and as a standalone bench target for initiator stages.

Parameters:
- AW, 10, word-address width; memory holds 2^AW 32-bit words.
- DEPTH, 4, maximum outstanding (accepted, not yet responded) requests; power of two, >=1.
- LATENCY, 3, cycles from accept edge to data_ok; >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  initiator request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  transfer size; 0 = byte, 1 = half, 2 = word. Ignored: wstrb governs writes, reads return a full word.
- addr  in  32  byte address; word index = addr[AW+1:2]; bits above AW+1 are ignored (aliasing).
- wstrb  in  4  byte write enables (bit i -> wdata[8i+7:8i]).
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  response valid this cycle (one pulse per accepted request).
- rdata  out  32  read data; valid when data_ok is high.
- addr_stall  in  1  test hook; forces addr_ok low while high.
- outstanding  out  $clog2(DEPTH+1)  number of accepted requests not yet responded.

Behaviour:
- Accept condition:
  - addr_ok = req && !addr_stall && (outstanding < DEPTH), combinational.
  - A handshake is req && addr_ok at a rising edge.
  - A same-cycle pop does not free a slot for addr_ok in that cycle (conservative full check).
- Write commit:
  - On the handshake edge, mem[idx] bytes with wstrb[i]=1 take wdata bytes.
  - wstrb=0 is a no-op write that still produces a response.
- Read capture:
  - On the handshake edge, the response entry stores mem[idx] as it was before any same-edge write. Only one request can be accepted per cycle, so no same-edge write exists.
  - A read accepted after a write to the same word sees the written data (program order).
- Response queue:
  - Circular FIFO of DEPTH entries; each entry holds {rdata, countdown}.
  - Enqueue on handshake with countdown = LATENCY-1.
  - Every cycle, each valid entry with countdown > 0 decrements (saturating at 0).
- Response output:
  - data_ok = head valid && head countdown == 0.
  - The head pops at the edge ending that cycle.
  - Timing: handshake at edge N means data_ok is high during cycle N+LATENCY at the earliest (LATENCY=1 gives data_ok in the cycle immediately after accept).
  - Back-to-back accepts give back-to-back data_ok, one per cycle, in accept order.
  - No backpressure on data_ok: the initiator must consume it.
- Write responses: data_ok is pulsed; rdata = 32'h0.
- Idle outputs: rdata = 32'h0 whenever data_ok is low.
- outstanding counter:
  - +1 on handshake, -1 on pop, unchanged when both occur together.
  - Never exceeds DEPTH.
- Reset (synchronous):
  - Clears FIFO pointers, entry valids and outstanding to 0.
  - addr_ok follows req && !addr_stall from the cycle after reset (outstanding = 0).
  - data_ok = 0, rdata = 0.
  - Memory contents are not reset and persist across reset.
  - Reset mid-operation discards all pending responses; no data_ok for them ever appears.
  - A req asserted during a reset cycle is not accepted: addr_ok is forced 0 while rst = 1.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - Addresses alias modulo 2^AW words.
  - No error response exists.

Test Plan:
1. Single read, LATENCY=3: preload mem[5] = 32'hDEADBEEF; req=1, wr=0, addr=32'h14 accepted at edge 0 -> data_ok high only in cycle 3, rdata = 32'hDEADBEEF; outstanding goes 1,1,1 then 0 after the pop.
2. Byte-strobe write then read: write addr=32'h20, wstrb=4'b0101, wdata=32'h11223344 over mem[8] = 32'hAAAAAAAA, then read addr=32'h20 -> write data_ok with rdata = 0, then read data_ok with rdata = 32'hAA22AA44, responses in consecutive cycles.
3. Full queue, DEPTH=4: req held high for 6 cycles with reads of mem[0..5] -> first 4 accepted on consecutive edges; addr_ok low while outstanding = 4; 5th accepted only in the cycle after the first data_ok pop; data in order mem[0], mem[1], ...
4. addr_stall: req=1 with addr_stall=1 for 3 cycles -> addr_ok=0, outstanding=0, no data_ok; deassert stall -> accept the same cycle, data_ok LATENCY cycles later.
5. Reset mid-flight: accept 3 reads, assert rst 1 cycle after the last accept -> no data_ok ever for them, outstanding=0; a subsequent read of a previously written word returns the pre-reset written value.
6. Alias and LATENCY=1: read addr=32'h00001014 with AW=10 -> returns mem[5]; data_ok in the cycle right after accept; continuous req gives data_ok every cycle.

Source files
------------

// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of the sram-like bus backed by a word memory, in-order fixed-latency responses.
// Ports: clk/rst (sync, active-high); req/wr/size/addr/wstrb/wdata request side;
// addr_ok accept strobe; data_ok/rdata response side; addr_stall forces addr_ok low;
// outstanding counts accepted requests still awaiting their data_ok.
module sram_like_responder #(
   parameter int AW      = 10,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req,
   input  logic                       wr,
   input  logic [1:0]                 size,
   input  logic [31:0]                addr,
   input  logic [3:0]                 wstrb,
   input  logic [31:0]                wdata,
   output logic                       addr_ok,
   output logic                       data_ok,
   output logic [31:0]                rdata,
   input  logic                       addr_stall,
   output logic [$clog2(DEPTH+1)-1:0] outstanding
);
   localparam int OW = $clog2(DEPTH+1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
   logic [31:0]   mem    [2**AW];
   logic [31:0]   q_data [DEPTH];
   logic [CW-1:0] q_cnt  [DEPTH];
   logic [DEPTH-1:0] q_vld;
   logic [PW-1:0] wp, rp;
   logic [AW-1:0] idx;
   logic          push, pop;
   logic          unused_ok;
   assign unused_ok = ^{size, addr[31:AW+2], addr[1:0]};
   assign idx     = addr[AW+1:2];
   // full check uses the registered count, so a same-cycle pop never frees a slot early
   assign addr_ok = req && !addr_stall && !rst && (outstanding < OW'(DEPTH));
   assign push    = addr_ok;
   // responses are suppressed during reset so discarded entries never surface
   assign data_ok = !rst && q_vld[rp] && (q_cnt[rp] == '0);
   assign pop     = data_ok;
   assign rdata   = data_ok ? q_data[rp] : 32'h0;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp          <= '0;
         rp          <= '0;
         q_vld       <= '0;
         outstanding <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (q_vld[i] && q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
         if (pop) begin
            q_vld[rp] <= 1'b0;
            rp        <= rp == PW'(DEPTH-1) ? '0 : rp + 1'b1;
         end
         // the slot at wp is always free when push is allowed, so it never collides with the pop
         if (push) begin
            q_vld[wp]  <= 1'b1;
            q_cnt[wp]  <= CW'(LATENCY-1);
            q_data[wp] <= wr ? 32'h0 : mem[idx];
            wp         <= wp == PW'(DEPTH-1) ? '0 : wp + 1'b1;
         end
         outstanding <= outstanding + OW'(push) - OW'(pop);
      end
   end
   // memory is never reset; contents survive rst
   always_ff @(posedge clk)
      if (push && wr)
         for (int i = 0; i < 4; i++)
            if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed checks of three responder instances (LATENCY 3, 1, 5).
module tb_sram_like_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic        wr, addr_stall;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   logic        aok [3];
   logic        dok [3];
   logic [31:0] rd  [3];
   logic [2:0]  outs [3];
   int vectors = 0, misses = 0;
   always #5 clk = ~clk;
   sram_like_responder #(.AW(10), .DEPTH(4), .LATENCY(3)) u0 (
      .clk(clk), .rst(rst), .req(req[0]), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
      .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]), .addr_stall(addr_stall),
      .outstanding(outs[0]));
   sram_like_responder #(.AW(10), .DEPTH(4), .LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .req(req[1]), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
      .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]), .addr_stall(addr_stall),
      .outstanding(outs[1]));
   sram_like_responder #(.AW(10), .DEPTH(4), .LATENCY(5)) u2 (
      .clk(clk), .rst(rst), .req(req[2]), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
      .wdata(wdata), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2]), .addr_stall(addr_stall),
      .outstanding(outs[2]));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         misses++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask
   task automatic obs(input int d, input string tag, input logic ea, input logic ed,
                      input logic [31:0] er, input logic [2:0] eo);
      check({tag, ".addr_ok"}, 32'(aok[d]), 32'(ea));
      check({tag, ".data_ok"}, 32'(dok[d]), 32'(ed));
      check({tag, ".rdata"}, rd[d], er);
      check({tag, ".outstanding"}, 32'(outs[d]), 32'(eo));
   endtask
   // inputs change on the falling edge; outputs are sampled 1 time unit later
   task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd, input logic st);
      @(negedge clk);
      req = r ? 3'(1 << d) : 3'b0;
      wr = w;
      addr = a;
      wstrb = s;
      wdata = wd;
      addr_stall = st;
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
   endtask
   task automatic put(input int d, input logic [31:0] a, input logic [31:0] wd);
      drive(d, 1'b1, 1'b1, a, 4'hF, wd, 1'b0);
      idle(7);
   endtask
   function automatic logic [31:0] val(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h111;
   endfunction
   int t3_req [14] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0};
   int t3_idx [14] = '{0,1,2,3,4,4,4,5,0,0,0,0,0,0};
   int t3_aok [14] = '{1,1,1,1,0,0,1,1,0,0,0,0,0,0};
   int t3_rdi [14] = '{-1,-1,-1,-1,-1,0,1,2,3,-1,-1,4,5,-1};
   int t3_out [14] = '{0,1,2,3,4,4,3,3,3,2,2,2,1,0};
   logic [31:0] t6_addr [5] = '{32'h1014, 32'h1018, 32'h1014, 32'h0, 32'h0};
   int          t6_req  [5] = '{1,1,1,0,0};
   int          t6_dok  [5] = '{0,1,1,1,0};
   logic [31:0] t6_rd   [5] = '{32'h0, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'h0};
   int          t6_out  [5] = '{0,1,1,1,0};
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b1; req = 3'b0; wr = 1'b0; size = 2'd2; addr = 32'h0;
      wstrb = 4'h0; wdata = 32'h0; addr_stall = 1'b0;
      @(negedge clk); req = 3'b111; addr = 32'h14; #1;
      for (int d = 0; d < 3; d++) check($sformatf("rst_aok%0d", d), 32'(aok[d]), 32'h0);
      @(negedge clk); rst = 1'b0; #1;
      for (int d = 0; d < 3; d++) obs(d, $sformatf("post_rst%0d", d), 1'b1, 1'b0, 32'h0, 3'd0);
      idle(1);
      put(0, 32'h14, 32'hDEADBEEF);
      put(0, 32'h20, 32'hAAAAAAAA);
      for (int i = 0; i < 6; i++) put(2, 32'(i * 4), val(i));
      put(1, 32'h14, 32'hCAFEF00D);
      put(1, 32'h18, 32'h12345678);
      drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b0); obs(0, "t1c0", 1'b1, 1'b0, 32'h0, 3'd0);
      idle(1); obs(0, "t1c1", 1'b0, 1'b0, 32'h0, 3'd1);
      idle(1); obs(0, "t1c2", 1'b0, 1'b0, 32'h0, 3'd1);
      idle(1); obs(0, "t1c3", 1'b0, 1'b1, 32'hDEADBEEF, 3'd1);
      idle(1); obs(0, "t1c4", 1'b0, 1'b0, 32'h0, 3'd0);
      drive(0, 1'b1, 1'b1, 32'h20, 4'b0101, 32'h11223344, 1'b0); check("t2_wr_aok", 32'(aok[0]), 32'h1);
      drive(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0); check("t2_rd_aok", 32'(aok[0]), 32'h1);
      idle(1); check("t2_c2_dok", 32'(dok[0]), 32'h0);
      idle(1); obs(0, "t2_wresp", 1'b0, 1'b1, 32'h0, 3'd2);
      idle(1); obs(0, "t2_rresp", 1'b0, 1'b1, 32'hAA22AA44, 3'd1);
      idle(1); obs(0, "t2_done", 1'b0, 1'b0, 32'h0, 3'd0);
      drive(0, 1'b1, 1'b1, 32'h14, 4'h0, 32'hFFFFFFFF, 1'b0);
      idle(2);
      idle(1); obs(0, "nop_wresp", 1'b0, 1'b1, 32'h0, 3'd1);
      idle(1);
      for (int c = 0; c < 3; c++) begin
         drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b1);
         obs(0, $sformatf("t4_stall%0d", c), 1'b0, 1'b0, 32'h0, 3'd0);
      end
      drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b0); check("t4_accept", 32'(aok[0]), 32'h1);
      idle(2);
      idle(1); obs(0, "t4_resp", 1'b0, 1'b1, 32'hDEADBEEF, 3'd1);
      idle(1);
      drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b0);
      drive(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
      drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b0);
      @(negedge clk); req = 3'b0; rst = 1'b1; #1;
      check("t5_rst_dok", 32'(dok[0]), 32'h0);
      @(negedge clk); rst = 1'b0; #1;
      obs(0, "t5_after", 1'b0, 1'b0, 32'h0, 3'd0);
      for (int c = 0; c < 4; c++) begin
         idle(1); check($sformatf("t5_quiet%0d", c), 32'(dok[0]), 32'h0);
      end
      drive(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0); check("t5_accept", 32'(aok[0]), 32'h1);
      idle(2);
      idle(1); obs(0, "t5_resp", 1'b0, 1'b1, 32'hAA22AA44, 3'd1);
      idle(1);
      for (int c = 0; c < 14; c++) begin
         drive(2, t3_req[c] != 0, 1'b0, 32'(t3_idx[c] * 4), 4'h0, 32'h0, 1'b0);
         obs(2, $sformatf("t3c%0d", c), t3_aok[c] != 0, t3_rdi[c] >= 0,
             t3_rdi[c] >= 0 ? val(t3_rdi[c]) : 32'h0, 3'(t3_out[c]));
      end
      for (int c = 0; c < 5; c++) begin
         drive(1, t6_req[c] != 0, 1'b0, t6_addr[c], 4'h0, 32'h0, 1'b0);
         obs(1, $sformatf("t6c%0d", c), t6_req[c] != 0, t6_dok[c] != 0, t6_rd[c], 3'(t6_out[c]));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end
endmodule
